// File: rtl/synth_pkg.sv
// Shared constants for the oscillator parameter path: register ids, field widths,
// parser states and the payload-length lookup.
package synth_pkg;

  localparam int unsigned W_WAVE  = 8;
  localparam int unsigned W_FREQ  = 24;
  localparam int unsigned W_PHASE = 16;
  localparam int unsigned W_AMP   = 16;

  localparam logic [3:0] REG_WAVE    = 4'h0;
  localparam logic [3:0] REG_FREQ    = 4'h1;
  localparam logic [3:0] REG_PHASE   = 4'h2;
  localparam logic [3:0] REG_AMP     = 4'h3;
  localparam logic [3:0] CMD_CLR_ERR = 4'hE;
  localparam logic [3:0] CMD_COMMIT  = 4'hF;

  typedef enum logic {
    ST_IDLE,
    ST_PAYLOAD
  } state_e;

  // Payload bytes following a header; 0 marks ids that carry no register write.
  function automatic logic [1:0] payload_len(input logic [3:0] id);
    case (id)
      REG_WAVE:           return 2'd1;
      REG_FREQ:           return 2'd3;
      REG_PHASE, REG_AMP: return 2'd2;
      default:            return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/osc_param_bank.sv
// Per-oscillator shadow/active register pair; shadow is written by the parser,
// active is loaded from shadow as a whole on commit.
module osc_param_bank
  import synth_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [3:0]         reg_i,
  input  logic [W_FREQ-1:0]  data_i,
  input  logic               commit_i,
  output logic [W_WAVE-1:0]  wave_o,
  output logic [W_FREQ-1:0]  freq_o,
  output logic [W_PHASE-1:0] phase_o,
  output logic [W_AMP-1:0]   amp_o
);

  logic [W_WAVE-1:0]  sh_wave_q,  act_wave_q;
  logic [W_FREQ-1:0]  sh_freq_q,  act_freq_q;
  logic [W_PHASE-1:0] sh_phase_q, act_phase_q;
  logic [W_AMP-1:0]   sh_amp_q,   act_amp_q;

  // Commit samples the shadow before any same-edge write lands.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_wave_q   <= '0;
      sh_freq_q   <= '0;
      sh_phase_q  <= '0;
      sh_amp_q    <= '0;
      act_wave_q  <= '0;
      act_freq_q  <= '0;
      act_phase_q <= '0;
      act_amp_q   <= '0;
    end else begin
      if (we_i) begin
        case (reg_i)
          REG_WAVE:  sh_wave_q  <= data_i[W_WAVE-1:0];
          REG_FREQ:  sh_freq_q  <= data_i;
          REG_PHASE: sh_phase_q <= data_i[W_PHASE-1:0];
          REG_AMP:   sh_amp_q   <= data_i[W_AMP-1:0];
          default:   ;
        endcase
      end
      if (commit_i) begin
        act_wave_q  <= sh_wave_q;
        act_freq_q  <= sh_freq_q;
        act_phase_q <= sh_phase_q;
        act_amp_q   <= sh_amp_q;
      end
    end
  end

  assign wave_o  = act_wave_q;
  assign freq_o  = act_freq_q;
  assign phase_o = act_phase_q;
  assign amp_o   = act_amp_q;

endmodule

// File: rtl/osc_param_ctrl.sv
// SPI byte-stream packet parser feeding per-oscillator parameter banks, with
// inter-byte timeout, sticky error and frame-synchronous commit.
module osc_param_ctrl
  import synth_pkg::*;
#(
  parameter int N_OSC       = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_data,
  input  logic                 i_data_load,
  input  logic                 i_frame_tick,
  output logic [8*N_OSC-1:0]   o_osc_wave,
  output logic [24*N_OSC-1:0]  o_osc_freq,
  output logic [16*N_OSC-1:0]  o_osc_phase,
  output logic [16*N_OSC-1:0]  o_osc_amp,
  output logic                 o_busy,
  output logic                 o_applied,
  output logic                 o_err
);

  localparam int IW = $clog2(TIMEOUT_CYC) + 1;

  state_e             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [W_FREQ-1:0]  asm_q, asm_d;
  logic [3:0]         reg_q, reg_d;
  logic [3:0]         osc_q, osc_d;
  logic [IW-1:0]      idle_q, idle_d;
  logic               pending_q, pending_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               applied_q;
  logic               wr_en;
  logic               commit;
  logic [3:0]         hdr_id, hdr_osc;

  assign hdr_id  = i_data[7:4];
  assign hdr_osc = i_data[3:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    reg_d     = reg_q;
    osc_d     = osc_q;
    idle_d    = idle_q;
    err_d     = err_q;
    wr_en     = 1'b0;
    commit    = i_frame_tick & pending_q;
    pending_d = pending_q & ~commit;

    case (state_q)
      ST_IDLE: begin
        if (i_data_load) begin
          if (hdr_id == CMD_COMMIT) begin
            pending_d = 1'b1;
          end else if (hdr_id == CMD_CLR_ERR) begin
            err_d = 1'b0;
          end else if ((payload_len(hdr_id) != 2'd0) && (int'(hdr_osc) < N_OSC)) begin
            state_d = ST_PAYLOAD;
            cnt_d   = payload_len(hdr_id);
            reg_d   = hdr_id;
            osc_d   = hdr_osc;
            asm_d   = '0;
            idle_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        // Expiry is checked before the strobe so a byte on the expiry edge is dropped.
        if (idle_q == IW'(TIMEOUT_CYC - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (i_data_load) begin
          asm_d  = {asm_q[W_FREQ-9:0], i_data};
          idle_d = '0;
          cnt_d  = cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            wr_en   = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) | pending_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      asm_q     <= '0;
      reg_q     <= '0;
      osc_q     <= '0;
      idle_q    <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      applied_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      reg_q     <= reg_d;
      osc_q     <= osc_d;
      idle_q    <= idle_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      applied_q <= commit;
    end
  end

  for (genvar k = 0; k < N_OSC; k++) begin : g_bank
    osc_param_bank u_bank (
      .clk_i    (i_clk),
      .rst_i    (i_rst),
      .we_i     (wr_en && (int'(osc_q) == k)),
      .reg_i    (reg_q),
      .data_i   (asm_d),
      .commit_i (commit),
      .wave_o   (o_osc_wave[8*k +: 8]),
      .freq_o   (o_osc_freq[24*k +: 24]),
      .phase_o  (o_osc_phase[16*k +: 16]),
      .amp_o    (o_osc_amp[16*k +: 16])
    );
  end

  assign o_busy    = busy_q;
  assign o_applied = applied_q;
  assign o_err     = err_q;

endmodule
